// File: rtl/async_fifo_pkg.sv
// Shared helpers for the async FIFO read- and write-side controllers.
// The Gray conversions work on a fixed wide vector. Callers zero-extend
// their pointer into it and truncate the result, so one function body
// serves any pointer width up to PTR_W_MAX.
package async_fifo_pkg;

  localparam int unsigned PTR_W_MAX = 32;

  typedef logic [PTR_W_MAX-1:0] ptr_t;

  // Pointer width including the wrap bit, for a power-of-two DEPTH
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = g;
    for (int unsigned i = 1; i < PTR_W_MAX; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
// Shared by the read-side and write-side FIFO controllers.
module async_fifo_sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             sync_rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  // First flop catches the asynchronous input, second one settles it
  always_ff @(posedge clk) begin
    if (!sync_rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Async FIFO read-domain controller: read pointer, empty flag, read
// valid and underflow pulse, plus the Gray read pointer for the write
// domain. Optional macro ASYNC_FIFO_RD_LEVEL_EN adds a registered,
// conservative occupancy output rd_level.
module async_fifo_rd_ctrl
  import async_fifo_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = async_fifo_pkg::ptr_width(DEPTH)
) (
  input  logic             read_clk,
  input  logic             sync_rst,
  input  logic             read_en,
  input  logic [PTR_W-1:0] wptr_gray_in,
  output logic [PTR_W-1:0] raddr,
  output logic [PTR_W-1:0] rptr_gray,
  output logic             empty,
  output logic             rd_valid,
`ifdef ASYNC_FIFO_RD_LEVEL_EN
  output logic [PTR_W-1:0] rd_level,
`endif
  output logic             underflow
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("async_fifo_rd_ctrl: DEPTH must be a power of two and >= 2");
  end

  logic [PTR_W-1:0] wptr_gray_sync;
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rbin_next;
  logic [PTR_W-1:0] rgray_next;
  logic             rd_fire;

  async_fifo_sync_2ff #(
    .WIDTH(PTR_W)
  ) u_wptr_sync (
    .clk      (read_clk),
    .sync_rst (sync_rst),
    .d        (wptr_gray_in),
    .q        (wptr_gray_sync)
  );

  // Next read pointer; the binary counter wraps naturally at 2^PTR_W
  always_comb begin
    rd_fire    = read_en & ~empty;
    rbin_next  = rbin + PTR_W'(rd_fire);
    rgray_next = PTR_W'(bin2gray(ptr_t'(rbin_next)));
  end

  // Memory index drops the wrap bit so it stays within DEPTH
  assign raddr = {1'b0, rbin[PTR_W-2:0]};

  // Pointer, flag and pulse registers; empty uses the post-read pointer
  always_ff @(posedge read_clk) begin
    if (!sync_rst) begin
      rbin      <= '0;
      rptr_gray <= '0;
      empty     <= 1'b1;
      rd_valid  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rbin      <= rbin_next;
      rptr_gray <= rgray_next;
      empty     <= (rgray_next == wptr_gray_sync);
      rd_valid  <= rd_fire;
      underflow <= read_en & empty;
    end
  end

`ifdef ASYNC_FIFO_RD_LEVEL_EN
  logic [PTR_W-1:0] wbin_sync;

  // Synchronized write count in binary for the occupancy subtraction
  always_comb begin
    wbin_sync = PTR_W'(gray2bin(ptr_t'(wptr_gray_sync)));
  end

  // Occupancy lags writes by the synchronizer, so it never overstates
  always_ff @(posedge read_clk) begin
    if (!sync_rst) begin
      rd_level <= '0;
    end else begin
      rd_level <= wbin_sync - rbin_next;
    end
  end
`endif

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Bench for async_fifo_rd_ctrl. A count-based model (write count seen
// through a two-cycle delay line, read count, occupancy) is compared on
// every cycle; directed steps add literal expectations. Define
// ASYNC_FIFO_RD_LEVEL_EN for both RTL and bench to cover rd_level.
module tb_async_fifo_rd_ctrl;

  localparam int DEPTH = 16;
  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int MODV  = 2 * DEPTH;

  localparam int SIG_RADDR = 0;
  localparam int SIG_RGRAY = 1;
  localparam int SIG_EMPTY = 2;
  localparam int SIG_VALID = 3;
  localparam int SIG_UFLOW = 4;
  localparam int SIG_LEVEL = 5;
  localparam int SIG_BENCH = 6;

  logic             read_clk = 1'b0;
  logic             sync_rst;
  logic             read_en;
  logic [PTR_W-1:0] wptr_gray_in;
  logic [PTR_W-1:0] raddr;
  logic [PTR_W-1:0] rptr_gray;
  logic             empty;
  logic             rd_valid;
  logic             underflow;
`ifdef ASYNC_FIFO_RD_LEVEL_EN
  logic [PTR_W-1:0] rd_level;
`endif

  async_fifo_rd_ctrl #(
    .DEPTH(DEPTH)
  ) dut (
    .read_clk     (read_clk),
    .sync_rst     (sync_rst),
    .read_en      (read_en),
    .wptr_gray_in (wptr_gray_in),
    .raddr        (raddr),
    .rptr_gray    (rptr_gray),
    .empty        (empty),
    .rd_valid     (rd_valid),
`ifdef ASYNC_FIFO_RD_LEVEL_EN
    .rd_level     (rd_level),
`endif
    .underflow    (underflow)
  );

  always #5 read_clk = ~read_clk;

  // Reference helpers: Gray encode by definition, decode by search
  function automatic int gray_of(input int b);
    int m;
    m = b % MODV;
    return (m ^ (m >> 1));
  endfunction

  function automatic int bin_of_gray(input int g);
    for (int b = 0; b < MODV; b++) begin
      if (gray_of(b) == g) return b;
    end
    return -1;
  endfunction

  // Model state: counts of entries written (as seen after two flops) and read
  int m_w1, m_w2, m_rd, m_level;
  bit m_empty, m_valid, m_uf;

  always @(posedge read_clk) begin
    bit take;
    if (!sync_rst) begin
      m_w1 = 0; m_w2 = 0; m_rd = 0; m_level = 0;
      m_empty = 1'b1; m_valid = 1'b0; m_uf = 1'b0;
    end else begin
      take    = read_en && !m_empty;
      m_uf    = read_en && m_empty;
      m_valid = take;
      m_rd    = (m_rd + (take ? 1 : 0)) % MODV;
      m_level = (m_w2 - m_rd + MODV) % MODV;
      m_empty = (m_level == 0);
      m_w2    = m_w1;
      m_w1    = bin_of_gray(int'(wptr_gray_in));
    end
  end

  typedef struct {
    string name;
    int    sel;
    int    exp;
    int    act;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;

  function automatic int sig_val(input int sel, input int act);
    case (sel)
      SIG_RADDR: return int'(raddr);
      SIG_RGRAY: return int'(rptr_gray);
      SIG_EMPTY: return int'(empty);
      SIG_VALID: return int'(rd_valid);
      SIG_UFLOW: return int'(underflow);
`ifdef ASYNC_FIFO_RD_LEVEL_EN
      SIG_LEVEL: return int'(rd_level);
`endif
      default:   return act;
    endcase
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: model check every cycle plus queued literals
  always @(negedge read_clk) begin
    exp_t e;
    if (chk_en) begin
      cmp("model_raddr", int'(raddr), m_rd % DEPTH);
      cmp("model_rptr_gray", int'(rptr_gray), gray_of(m_rd));
      cmp("model_empty", int'(empty), int'(m_empty));
      cmp("model_rd_valid", int'(rd_valid), int'(m_valid));
      cmp("model_underflow", int'(underflow), int'(m_uf));
`ifdef ASYNC_FIFO_RD_LEVEL_EN
      cmp("model_rd_level", int'(rd_level), m_level);
`endif
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp(e.name, sig_val(e.sel, e.act), e.exp);
    end
  end

  task automatic expect_sig(input string name, input int sel, input int exp);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = exp; e.act = 0;
    exp_q.push_back(e);
  endtask

  task automatic expect_bench(input string name, input int act, input int exp);
    exp_t e;
    e.name = name; e.sel = SIG_BENCH; e.exp = exp; e.act = act;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge read_clk);
    #1;
  endtask

  task automatic do_reset();
    sync_rst = 1'b0;
    read_en  = 1'b0;
    wptr_gray_in = '0;
    tick();
    sync_rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int reads;
    int w;
    bit fire;

    // 1: reset held 3 cycles with read_en high and a nonzero write pointer
    sync_rst = 1'b0;
    read_en  = 1'b1;
    wptr_gray_in = 5'h03;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_en = 1'b1;
      expect_sig("rst_empty", SIG_EMPTY, 1);
      expect_sig("rst_raddr", SIG_RADDR, 0);
      expect_sig("rst_rptr_gray", SIG_RGRAY, 0);
      expect_sig("rst_rd_valid", SIG_VALID, 0);
      expect_sig("rst_underflow", SIG_UFLOW, 0);
    end

    // 2: one write arrives; empty drops after 3 edges, then one read
    sync_rst = 1'b1;
    read_en  = 1'b0;
    wptr_gray_in = '0;
    tick();
    wptr_gray_in = 5'h01;
    tick();
    tick();
    expect_sig("lat_empty_edge2", SIG_EMPTY, 1);
    tick();
    expect_sig("lat_empty_edge3", SIG_EMPTY, 0);
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    expect_sig("rd1_raddr", SIG_RADDR, 1);
    expect_sig("rd1_rptr_gray", SIG_RGRAY, 5'h01);
    expect_sig("rd1_empty", SIG_EMPTY, 1);
    expect_sig("rd1_rd_valid", SIG_VALID, 1);

    // 3: reads while empty produce underflow and no pointer motion
    read_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      expect_sig("uf_pulse", SIG_UFLOW, 1);
      expect_sig("uf_rd_valid", SIG_VALID, 0);
      expect_sig("uf_raddr", SIG_RADDR, 1);
    end
    read_en = 1'b0;
    tick();
    expect_sig("uf_cleared", SIG_UFLOW, 0);

    // 4: wrap through 32 reads with writes kept ahead
    do_reset();
    reads = 0;
    w = 0;
    read_en = 1'b1;
    for (int c = 0; c < 80 && reads < 32; c++) begin
      if (w < 32) w++;
      wptr_gray_in = PTR_W'(gray_of(w));
      fire = !empty;
      if (fire) expect_sig("wrap_raddr", SIG_RADDR, reads % DEPTH);
      tick();
      if (fire) begin
        reads++;
        if (reads == 16) expect_sig("wrap_gray_bin16", SIG_RGRAY, 5'h18);
        if (reads == 32) expect_sig("wrap_gray_back0", SIG_RGRAY, 0);
      end
    end
    read_en = 1'b0;
    expect_bench("wrap_read_count", reads, 32);
    for (int i = 0; i < 4; i++) tick();
    expect_sig("wrap_empty_at_w0", SIG_EMPTY, 1);

    // 5: occupancy after five writes, then two reads
    do_reset();
    wptr_gray_in = PTR_W'(gray_of(5));
    tick();
    tick();
    tick();
    expect_sig("lvl5_empty", SIG_EMPTY, 0);
`ifdef ASYNC_FIFO_RD_LEVEL_EN
    expect_sig("lvl_5", SIG_LEVEL, 5);
`endif
    read_en = 1'b1;
    tick();
`ifdef ASYNC_FIFO_RD_LEVEL_EN
    expect_sig("lvl_4", SIG_LEVEL, 4);
`endif
    tick();
    read_en = 1'b0;
`ifdef ASYNC_FIFO_RD_LEVEL_EN
    expect_sig("lvl_3", SIG_LEVEL, 3);
`endif
    expect_sig("lvl_raddr2", SIG_RADDR, 2);

    // 6: reset mid-stream after 7 of 9 entries read
    do_reset();
    wptr_gray_in = PTR_W'(gray_of(9));
    tick();
    tick();
    tick();
    read_en = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    expect_sig("mid_raddr7", SIG_RADDR, 7);
    sync_rst = 1'b0;
    tick();
    sync_rst = 1'b1;
    read_en  = 1'b0;
    expect_sig("mid_rst_raddr", SIG_RADDR, 0);
    expect_sig("mid_rst_rptr_gray", SIG_RGRAY, 0);
    expect_sig("mid_rst_empty", SIG_EMPTY, 1);
    expect_sig("mid_rst_rd_valid", SIG_VALID, 0);
    tick();
    tick();
    expect_sig("mid_resync_empty2", SIG_EMPTY, 1);
    tick();
    expect_sig("mid_resync_empty3", SIG_EMPTY, 0);

    tick();
    @(negedge read_clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
